// File: rtl/bcd2bin_conv_pkg.sv
// Shared definitions for the packed-BCD to binary converter: FSM state
// encoding, digit width and a digit validity helper.
package bcd2bin_conv_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // True for nibbles that cannot appear in a legal BCD digit (A..F).
  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: after a right shift, a digit that
// is 8 or more has 3 subtracted (the inverse of the "add 3 if >=5" step).
module bcd_digit_adj
  import bcd2bin_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd2bin_conv.sv
// Sequential packed-BCD to binary converter, one bit per cycle, valid/ready on
// both sides. Optional input digit check enabled by defining BCD_CHECK_EN.
module bcd2bin_conv
  import bcd2bin_conv_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 10
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_bin,
  output logic                      out_err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  state_t           state;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_next;
  logic [OUT_W-1:0] bin_reg;
  logic [OUT_W-1:0] bin_next;
  logic [CNT_W-1:0] cnt;

  // The bit leaving the bottom of the BCD register enters the binary
  // register from the top; after OUT_W steps the LSB has reached bit 0.
  assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
  assign bin_next  = {bcd_reg[0], bin_reg[OUT_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_next[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_CHECK_EN
  logic bad_digit;
  logic err_reg;

  // NOTE: assign the default before the loop so every path writes the
  // signal; otherwise synthesis infers a latch.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad_digit = bad_digit | digit_invalid(in_bcd[i*DIGIT_W +: DIGIT_W]);
  end

  assign out_err = err_reg;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      out_bin <= '0;
`ifdef BCD_CHECK_EN
      err_reg <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            bcd_reg <= in_bcd;
            bin_reg <= '0;
            cnt     <= '0;
`ifdef BCD_CHECK_EN
            if (bad_digit) begin
              state   <= ST_DONE;
              out_bin <= '0;
              err_reg <= 1'b1;
            end else begin
              state   <= ST_SHIFT;
              err_reg <= 1'b0;
            end
`else
            state <= ST_SHIFT;
`endif
          end
        end

        ST_SHIFT: begin
          bin_reg <= bin_next;
          bcd_reg <= bcd_next;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state   <= ST_DONE;
            out_bin <= bin_next;
          end
        end

        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_conv.sv
// Directed bench for bcd2bin_conv: latency, back-to-back, stall, async reset,
// digit check (when BCD_CHECK_EN is defined) and a full sweep of 000..999.
module tb_bcd2bin_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_bin;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  bcd2bin_conv #(.DIGITS(3), .OUT_W(10)) dut (
    .clk       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic accept(input logic [11:0] bcd);
    int n = 0;
    in_bcd   = bcd;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 60), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts clock edges from acceptance (inclusive) to out_valid visible.
  task automatic wait_out(output int lat, output int ready_seen);
    lat = 1;
    ready_seen = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) ready_seen++;
      @(negedge clk);
      lat++;
    end
    check("out_valid_timeout", 32'(out_valid), 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 0);
    check("post_hs_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int lat, rdy, seen1, n, hs, handshakes, vcount;
    logic [11:0] bcd;

    rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_bin",   32'(out_bin),   0);
    check("rst_out_err",   32'(out_err),   0);
    rst = 1'b0;
    @(negedge clk);

    // 999 -> 0x3E7, 11 edges, busy throughout
    accept(12'h999);
    wait_out(lat, rdy);
    check("t999_lat",   lat, 11);
    check("t999_busy",  rdy, 0);
    check("t999_bin",   32'(out_bin), 32'h3E7);
    check("t999_err",   32'(out_err), 0);
    handshake();

    // 000 then 512 back to back with out_ready held high
    out_ready = 1'b1;
    accept(12'h000);
    in_bcd   = 12'h512;
    in_valid = 1'b1;
    seen1 = 0;
    n = 0;
    while (!in_ready && n < 60) begin
      if (out_valid) begin
        seen1 = 1;
        check("b2b_bin0", 32'(out_bin), 0);
      end
      @(negedge clk);
      n++;
    end
    check("b2b_order", seen1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat, rdy);
    check("b2b_lat", lat, 11);
    check("b2b_bin", 32'(out_bin), 32'h200);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_drop", 32'(out_valid), 0);

    // 255 held for 20 cycles with out_ready low
    accept(12'h255);
    wait_out(lat, rdy);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_bin",   32'(out_bin),   32'h0FF);
    end
    handshake();

    // asynchronous reset in the middle of SHIFT
    accept(12'h999);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_bin",   32'(out_bin),   0);
    check("arst_ready", 32'(in_ready),  1);
    check("arst_err",   32'(out_err),   0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("arst_no_valid", n, 0);
    accept(12'h100);
    wait_out(lat, rdy);
    check("t100_bin", 32'(out_bin), 32'h064);
    handshake();

`ifdef BCD_CHECK_EN
    accept(12'h1A3);
    wait_out(lat, rdy);
    check("inv_lat", lat, 1);
    check("inv_err", 32'(out_err), 1);
    check("inv_bin", 32'(out_bin), 0);
    handshake();
`else
    accept(12'h1A3);
    wait_out(lat, rdy);
    check("inv_lat", lat, 11);
    check("inv_err", 32'(out_err), 0);
    handshake();
`endif
    accept(12'h010);
    wait_out(lat, rdy);
    check("t010_bin", 32'(out_bin), 10);
    check("t010_err", 32'(out_err), 0);
    handshake();

    // full sweep with random out_ready stalls
    handshakes = 0;
    vcount = 0;
    for (int v = 0; v < 1000; v++) begin
      bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      accept(bcd);
      vcount++;
      hs = 0;
      n = 0;
      while (hs == 0 && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check("sweep_bin", 32'(out_bin), 32'(v));
          check("sweep_err", 32'(out_err), 0);
          hs = 1;
          handshakes++;
        end
        @(negedge clk);
        n++;
      end
      out_ready = 1'b0;
      check("sweep_timeout", 32'(hs), 1);
      check("sweep_single", 32'(out_valid), 0);
    end
    check("sweep_count", handshakes, vcount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
